// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - Request-to-SRAM phase sequencer for the 2048x16 split-half SRAM
module sram_controller (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Write,
    input  logic [10:0] Addr,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        Ack,
    output logic        Busy,
    output logic [10:0] AdxBus,
    inout  wire  [31:0] DataBus,
    output logic        OE,
    output logic        RNW,
    output logic        Clock1,
    output logic        Clock2,
    output logic        Clock3
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_ADR   = 3'd2;
    localparam logic [2:0] S_MDR   = 3'd3;
    localparam logic [2:0] S_WR    = 3'd4;
    localparam logic [2:0] S_RD    = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]  state_q, state_d;
    logic        write_q, write_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [10:0] adx_q, adx_d;
    logic        rnw_q, rnw_d;
    logic        oe_q, oe_d;
    logic        clk1_q, clk1_d;
    logic        clk2_q, clk2_d;
    logic        clk3_q, clk3_d;
    logic        drive_q, drive_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        accept;
    logic        next_idle;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    accept  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: state_d = S_ADR;
            S_ADR:   state_d = S_MDR;
            S_MDR:   state_d = write_q ? S_WR : S_RD;
            S_WR:    state_d = S_DONE;
            S_RD:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request fields latch on acceptance; the address register doubles as AdxBus
    always_comb begin
        write_d   = accept ? Write  : write_q;
        wr_data_d = accept ? WrData : wr_data_q;
        adx_d     = accept ? Addr   : adx_q;
        next_idle = (state_d == S_IDLE);

        // Every SRAM-side output is derived from the next state so it is flat for the whole state
        rnw_d   = next_idle ? 1'b1 : ~write_d;
        clk1_d  = write_d && (state_d == S_ADR);
        clk2_d  = write_d && (state_d == S_MDR);
        clk3_d  = (state_d == S_WR);
        oe_d    = (state_d != S_RD);
        drive_d = write_d && ((state_d == S_SETUP) || (state_d == S_ADR) ||
                              (state_d == S_MDR)   || (state_d == S_WR));
        ack_d   = (state_d == S_DONE);
        busy_d  = !next_idle;

        rd_data_d = (state_q == S_RD) ? DataBus : rd_data_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            write_q   <= 1'b0;
            wr_data_q <= 32'd0;
            adx_q     <= 11'd0;
            rnw_q     <= 1'b1;
            oe_q      <= 1'b1;
            clk1_q    <= 1'b0;
            clk2_q    <= 1'b0;
            clk3_q    <= 1'b0;
            drive_q   <= 1'b0;
            rd_data_q <= 32'd0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            wr_data_q <= wr_data_d;
            adx_q     <= adx_d;
            rnw_q     <= rnw_d;
            oe_q      <= oe_d;
            clk1_q    <= clk1_d;
            clk2_q    <= clk2_d;
            clk3_q    <= clk3_d;
            drive_q   <= drive_d;
            rd_data_q <= rd_data_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
        end
    end

    assign DataBus = drive_q ? wr_data_q : 32'bz;
    assign RdData  = rd_data_q;
    assign Ack     = ack_q;
    assign Busy    = busy_q;
    assign AdxBus  = adx_q;
    assign OE      = oe_q;
    assign RNW     = rnw_q;
    assign Clock1  = clk1_q;
    assign Clock2  = clk2_q;
    assign Clock3  = clk3_q;

endmodule
